// File: rtl/tcdm_bank_initiator.sv
// Command-driven fill/sweep master for a single TCDM bank port; read words leave on a valid/ready stream.
// Optional word-compare checker is enabled by defining TCDM_BANK_INIT_CHECK_EN.
module tcdm_bank_initiator #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]    cmd_len_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic                    cmd_incr_i,
`ifdef TCDM_BANK_INIT_CHECK_EN
    input  logic                    cmd_check_i,
    output logic                    err_o,
    output logic [15:0]             err_cnt_o,
`endif
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    bank_req_o,
    output logic                    bank_wen_o,
    output logic [ADDR_WIDTH-1:0]   bank_add_o,
    output logic [DATA_WIDTH-1:0]   bank_wdata_o,
    output logic [DATA_WIDTH/8-1:0] bank_be_o,
    input  logic [DATA_WIDTH-1:0]   bank_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_write;
    logic                  r_incr;
    logic                  r_done;
    logic                  r_inflight;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_pat;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_cnt;

    logic                  w_accept;
    logic                  w_req;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_done_nxt;
    logic [2:0]            w_occ;

    assign cmd_ready_o = (r_state == S_IDLE) & ~rst_i;
    assign w_accept    = cmd_valid_i & cmd_ready_o;
    assign rd_valid_o  = (r_cnt != 2'd0);
    assign w_pop       = rd_valid_o & rd_ready_i;
    assign w_push      = r_inflight;
    // Occupancy the FIFO will have once the current pop retires, counting the word still in the bank.
    assign w_occ       = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_len_i != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_req = r_write | (w_occ < 3'd2);
                if (w_req && (r_remain == LEN_WIDTH'(1))) begin
                    if (r_write) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_pop && (r_cnt == 2'd1) && !r_inflight) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_incr     <= 1'b0;
            r_done     <= 1'b0;
            r_inflight <= 1'b0;
            r_addr     <= '0;
            r_pat      <= '0;
            r_remain   <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_inflight <= w_req & ~r_write;
            if (w_accept) begin
                r_write  <= cmd_write_i;
                r_incr   <= cmd_incr_i;
                r_addr   <= cmd_addr_i;
                r_pat    <= cmd_wdata_i;
                r_remain <= cmd_len_i;
            end else if (w_req) begin
                r_addr   <= r_addr + ADDR_WIDTH'(1);
                r_remain <= r_remain - LEN_WIDTH'(1);
                if (r_incr) begin
                    r_pat <= r_pat + DATA_WIDTH'(1);
                end
            end
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // Storage is left unreset; rd_data_o is masked by rd_valid_o instead.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= bank_rdata_i;
        end
    end

    assign rd_data_o    = rd_valid_o ? r_fifo[r_rptr] : '0;
    assign busy_o       = (r_state != S_IDLE);
    assign done_o       = r_done;
    assign bank_req_o   = w_req;
    assign bank_wen_o   = ~(w_req & r_write);
    assign bank_add_o   = w_req ? r_addr : '0;
    assign bank_wdata_o = (w_req & r_write) ? r_pat : '0;
    assign bank_be_o    = w_req ? '1 : '0;

`ifdef TCDM_BANK_INIT_CHECK_EN
    logic                  r_check;
    logic [DATA_WIDTH-1:0] r_exp;
    logic                  r_err;
    logic [15:0]           r_err_cnt;

    // Expected value advances per popped word, not per request, since requests run ahead of the stream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_check   <= 1'b0;
            r_exp     <= '0;
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
        end else if (w_accept) begin
            r_check   <= cmd_check_i & ~cmd_write_i;
            r_exp     <= cmd_wdata_i;
            r_err     <= 1'b0;
            r_err_cnt <= 16'd0;
        end else if (w_pop) begin
            if (r_incr) begin
                r_exp <= r_exp + DATA_WIDTH'(1);
            end
            if (r_check && (rd_data_o != r_exp)) begin
                r_err <= 1'b1;
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
`endif

endmodule
